dq_bus_scheduler: RTL and testbench
===================================

Name: dq_bus_scheduler

Overview:
- Channel-level scheduler that owns the DQ bus direction (read vs write) and grants CAS slots to per-rank requesters.
- Drives channelMode/rankChanged into the channel's DQ turnaround timer and consumes its DQTurnaroundFree.
- Decides write-drain entry/exit from write-queue watermarks and a write-burst cap.
- Enforces tCCD between CAS grants and tRTRS on rank switches.
- Sits in the backend between per-rank command queues and the channel command issue stage.

Parameters:
- NUM_RANK, 2, number of ranks/requesters (>=2)
- WQ_DEPTH, 32, write-queue capacity; wrQueueCnt width = $clog2(WQ_DEPTH+1)
- WR_HIGH_WM, 24, enter write mode when wrQueueCnt >= this
- WR_LOW_WM, 8, leave write mode when wrQueueCnt <= this and reads are pending
- WR_BURST_MAX, 16, max accepted writes per write-mode visit while reads are pending
- tCCD, 4, min cycles between consecutive accepted CAS grants
- tRTRS, 2, extra gap when the granted rank differs from the previous grant's rank

Ports:
- clk, input, 1, clock
- rst, input, 1, asynchronous active-low reset
- rdReq, input, NUM_RANK, rank i has a read CAS ready
- wrReq, input, NUM_RANK, rank i has a write CAS ready
- wrQueueCnt, input, $clog2(WQ_DEPTH+1), current write-queue occupancy
- dqTurnaroundFree, input, 1, turnaround window expired
- grantValid, output, 1, CAS grant offered
- grantRank, output, $clog2(NUM_RANK), rank granted
- grantIsWrite, output, 1, grant direction (equals channelMode)
- grantReady, input, 1, issue stage accepts the grant
- channelMode, output, 1, 0 = READ, 1 = WRITE (registered)
- rankChanged, output, 1, first rank served in the new mode differs from the last granted rank (registered)

Behaviour:
- Reset (async, rst=0):
  - channelMode=0, rankChanged=0, grantValid=0, grantRank=0, grantIsWrite=0.
  - lastRank=0, rrPtr=0, ccdCnt=0, rtrsCnt=0, burstCnt=0.
  - Reset mid-grant drops grantValid immediately.
- FSM states: RD_MODE, WR_MODE. Mode is held in the channelMode register.
- Switch RD->WR when either:
  - wrQueueCnt >= WR_HIGH_WM, or
  - rdReq==0 and wrReq!=0.
- Switch WR->RD when rdReq!=0 and any of the following holds:
  - wrQueueCnt <= WR_LOW_WM
  - wrReq==0
  - burstCnt >= WR_BURST_MAX
- A switch is evaluated only when grantValid==0. On the switch edge:
  - channelMode toggles.
  - rankChanged <= (target != lastRank), where target is the round-robin pick from the new mode's request vector.
  - burstCnt <= 0.
- rankChanged holds until the next switch. The turnaround timer samples it in the first cycle of the new mode.
- Grant issue requires all of:
  - grantValid==0, dqTurnaroundFree==1, ccdCnt==0, no switch this cycle
  - a requesting rank exists in the current mode's vector
  - if the pick != lastRank, rtrsCnt==0 is also required
- Round-robin pick: scan from rrPtr upward with wrap and take the first set bit. If a different-rank pick is blocked by rtrsCnt, issue nothing that cycle (no fall-back to another rank).
- grantValid rises the cycle after the issue decision. grantRank and grantIsWrite are registered and held stable while grantValid && !grantReady.
- Accept (grantValid && grantReady):
  - grantValid <= 0 next cycle.
  - lastRank <= grantRank; rrPtr <= grantRank+1 (mod NUM_RANK).
  - ccdCnt <= tCCD-1; rtrsCnt <= tRTRS.
  - If in WR_MODE, burstCnt increments, saturating at WR_BURST_MAX.
- Back-to-back grants are therefore spaced by max(tCCD, 2) cycles minimum.
- Counters decrement by 1 per cycle when nonzero and saturate at 0.
- Simultaneous switch condition and grant candidate: the switch wins and no grant is issued that cycle.
- A requester deasserting while its grant is pending does not withdraw the grant. The issue stage owns that case.
- wrQueueCnt > WQ_DEPTH is illegal; only a simulation assertion is required.

Decomposition:
- Shared backend package (e.g. mc_backend_pkg):
  - mode_e (MODE_RD=0, MODE_WR=1)
  - default timing constants tCCD, tRTRS
  - rank index width function
- Sub-module rr_pick: combinational round-robin first-set-bit finder with pointer and wrap, NUM_RANK parameter.
  - Instanced twice: read vector and write vector.
  - The mode selects which result is used for issue and which for rankChanged.

Test Plan:
- Reset, rdReq=2'b01, wrReq=0, dqTurnaroundFree=1, grantReady=1 -> grantValid first high 1 cycle after reset release, grantRank=0, grantIsWrite=0; next grant spaced by 4 cycles.
- rdReq=2'b11 continuously, tRTRS=2, tCCD=4 -> grants alternate rank 0,1,0,1, each 4 cycles apart; rank switch never closer than the tRTRS gap.
- RD_MODE with rdReq=1, ramp wrQueueCnt 23->24 -> channelMode rises on the following edge; no grant issued while dqTurnaroundFree=0; first write grant once free returns 1.
- WR_MODE with wrQueueCnt=30 steady and rdReq=1 -> after 16 accepted writes channelMode returns to 0 and burstCnt clears.
- Last write on rank 0, read pending only on rank 1 -> rankChanged=1 registered together with channelMode=0; same rank -> rankChanged=0.
- grantValid high, grantReady held 0 for 5 cycles while the switch condition is true -> grant fields stable, no mode switch until accept, switch on the cycle after accept; async rst mid-hold -> all outputs 0 immediately.

Source files
------------

// File: rtl/dq_bus_scheduler_pkg.sv
// -----------------------------------------------------------------------------
// dq_bus_scheduler_pkg
// Shared backend definitions for the DQ bus scheduler:
//   mode_e          - DQ bus direction (MODE_RD = 0, MODE_WR = 1)
//   T_CCD_DEFAULT   - default minimum spacing between accepted CAS grants
//   T_RTRS_DEFAULT  - default extra gap on a rank switch
//   rank_w()        - width of a rank index (at least 1 bit)
//   cnt_w()         - width of a down-counter able to hold 0..n (at least 1 bit)
// -----------------------------------------------------------------------------
package dq_bus_scheduler_pkg;

  typedef enum logic {
    MODE_RD = 1'b0,
    MODE_WR = 1'b1
  } mode_e;

  localparam int T_CCD_DEFAULT  = 4;
  localparam int T_RTRS_DEFAULT = 2;

  function automatic int rank_w(input int num_rank);
    return (num_rank > 1) ? $clog2(num_rank) : 1;
  endfunction

  function automatic int cnt_w(input int max_val);
    return (max_val > 0) ? $clog2(max_val + 1) : 1;
  endfunction

endpackage

// File: rtl/dq_bus_scheduler_rr_pick.sv
// -----------------------------------------------------------------------------
// dq_bus_scheduler_rr_pick
// Combinational round-robin finder: scans req starting at ptr, moving upward
// with wrap-around, and returns the first set bit.
// Ports:
//   req   [NUM_RANK-1:0] in  - request vector
//   ptr   [RW-1:0]       in  - first index to examine (must be < NUM_RANK)
//   found                out - some bit of req is set
//   pick  [RW-1:0]       out - index of the winning bit (0 when !found)
// -----------------------------------------------------------------------------
module dq_bus_scheduler_rr_pick
  import dq_bus_scheduler_pkg::*;
#(
  parameter int NUM_RANK = 2,
  localparam int RW = rank_w(NUM_RANK)
) (
  input  logic [NUM_RANK-1:0] req,
  input  logic [RW-1:0]       ptr,
  output logic                found,
  output logic [RW-1:0]       pick
);

  // idx[gi] is the rank examined gi positions after ptr.
  logic [RW-1:0]       idx [NUM_RANK];
  logic [NUM_RANK-1:0] hit;

  for (genvar gi = 0; gi < NUM_RANK; gi++) begin : g_rot
    logic [RW:0] sum;
    // ptr < NUM_RANK, so one conditional subtract is enough for the wrap.
    assign sum     = {1'b0, ptr} + (RW + 1)'(gi);
    assign idx[gi] = (sum >= (RW + 1)'(NUM_RANK)) ? RW'(sum - (RW + 1)'(NUM_RANK))
                                                  : sum[RW-1:0];
    assign hit[gi] = req[idx[gi]];
  end

  // Walk from the farthest offset down so the nearest hit overwrites.
  always_comb begin
    found = 1'b0;
    pick  = '0;
    for (int i = NUM_RANK - 1; i >= 0; i--) begin
      if (hit[i]) begin
        found = 1'b1;
        pick  = idx[i];
      end
    end
  end

endmodule

// File: rtl/dq_bus_scheduler.sv
// -----------------------------------------------------------------------------
// dq_bus_scheduler
// Channel-level scheduler owning the DQ bus direction. Chooses read or write
// mode from write-queue watermarks and a write-burst cap, and hands out one
// CAS grant at a time to per-rank requesters, honouring tCCD between accepted
// grants and tRTRS on rank switches.
// Ports:
//   clk              in  - clock
//   rst              in  - asynchronous active-low reset
//   rdReq   [N-1:0]  in  - rank i has a read CAS ready
//   wrReq   [N-1:0]  in  - rank i has a write CAS ready
//   wrQueueCnt       in  - write-queue occupancy (0..WQ_DEPTH)
//   dqTurnaroundFree in  - turnaround window has expired
//   grantValid       out - CAS grant offered
//   grantRank        out - rank of the offered grant
//   grantIsWrite     out - direction of the offered grant
//   grantReady       in  - issue stage accepts the grant
//   channelMode      out - 0 = READ, 1 = WRITE
//   rankChanged      out - first rank of the new mode differs from last grant
// -----------------------------------------------------------------------------
module dq_bus_scheduler
  import dq_bus_scheduler_pkg::*;
#(
  parameter int NUM_RANK     = 2,
  parameter int WQ_DEPTH     = 32,
  parameter int WR_HIGH_WM   = 24,
  parameter int WR_LOW_WM    = 8,
  parameter int WR_BURST_MAX = 16,
  parameter int tCCD         = T_CCD_DEFAULT,
  parameter int tRTRS        = T_RTRS_DEFAULT,
  localparam int RW = rank_w(NUM_RANK),
  localparam int CW = $clog2(WQ_DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_RANK-1:0] rdReq,
  input  logic [NUM_RANK-1:0] wrReq,
  input  logic [CW-1:0]       wrQueueCnt,
  input  logic                dqTurnaroundFree,
  output logic                grantValid,
  output logic [RW-1:0]       grantRank,
  output logic                grantIsWrite,
  input  logic                grantReady,
  output logic                channelMode,
  output logic                rankChanged
);

  localparam int BW  = cnt_w(WR_BURST_MAX);
  localparam int CCW = cnt_w(tCCD);
  localparam int RTW = cnt_w(tRTRS);

  mode_e          mode_reg;
  logic           rank_changed_reg;
  logic           grant_valid_reg;
  logic           grant_is_write_reg;
  logic [RW-1:0]  grant_rank_reg;
  logic [RW-1:0]  last_rank_reg;
  logic [RW-1:0]  rr_ptr_reg;
  logic [CCW-1:0] ccd_cnt_reg;
  logic [RTW-1:0] rtrs_cnt_reg;
  logic [BW-1:0]  burst_cnt_reg;

  logic          rd_found, wr_found;
  logic [RW-1:0] rd_pick, wr_pick;
  logic          cur_found, new_found;
  logic [RW-1:0] cur_pick, new_pick;
  logic          accept, switch_cond, do_switch, do_issue;
  logic          ccd_ok, rtrs_ok;
  logic [RW-1:0] rr_ptr_next;

  // Both request vectors are scanned every cycle: the current mode's result
  // feeds grant issue, the other one predicts the first rank after a switch.
  dq_bus_scheduler_rr_pick #(.NUM_RANK(NUM_RANK)) u_rd_pick (
    .req   (rdReq),
    .ptr   (rr_ptr_reg),
    .found (rd_found),
    .pick  (rd_pick)
  );

  dq_bus_scheduler_rr_pick #(.NUM_RANK(NUM_RANK)) u_wr_pick (
    .req   (wrReq),
    .ptr   (rr_ptr_reg),
    .found (wr_found),
    .pick  (wr_pick)
  );

  always_comb begin
    accept = grant_valid_reg && grantReady;

    if (mode_reg == MODE_RD) begin
      switch_cond = (wrQueueCnt >= CW'(WR_HIGH_WM)) || (~|rdReq && |wrReq);
      cur_found   = rd_found;
      cur_pick    = rd_pick;
      new_found   = wr_found;
      new_pick    = wr_pick;
    end else begin
      switch_cond = |rdReq && ((wrQueueCnt <= CW'(WR_LOW_WM)) || ~|wrReq ||
                               (burst_cnt_reg >= BW'(WR_BURST_MAX)));
      cur_found   = wr_found;
      cur_pick    = wr_pick;
      new_found   = rd_found;
      new_pick    = rd_pick;
    end

    // The mode may only flip while no grant is outstanding.
    do_switch = !grant_valid_reg && switch_cond;

    // A grant decided now becomes visible next cycle, by which time the tCCD
    // counter has taken one more step; allowing issue at 1 makes accepted
    // grants exactly tCCD cycles apart (never closer than 2, the
    // valid/accept round trip).
    ccd_ok  = (ccd_cnt_reg <= CCW'(1));
    // A blocked rank switch stalls the whole cycle; there is no fall-back to
    // another rank.
    rtrs_ok = (cur_pick == last_rank_reg) || (rtrs_cnt_reg == '0);

    do_issue = !grant_valid_reg && dqTurnaroundFree && ccd_ok && rtrs_ok &&
               cur_found && !do_switch;

    rr_ptr_next = (grant_rank_reg == RW'(NUM_RANK - 1)) ? '0 : grant_rank_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg           <= MODE_RD;
      rank_changed_reg   <= 1'b0;
      grant_valid_reg    <= 1'b0;
      grant_is_write_reg <= 1'b0;
      grant_rank_reg     <= '0;
      last_rank_reg      <= '0;
      rr_ptr_reg         <= '0;
      ccd_cnt_reg        <= '0;
      rtrs_cnt_reg       <= '0;
      burst_cnt_reg      <= '0;
    end else begin
      if (accept) begin
        ccd_cnt_reg  <= CCW'(tCCD - 1);
        rtrs_cnt_reg <= RTW'(tRTRS);
      end else begin
        if (ccd_cnt_reg != '0) ccd_cnt_reg <= ccd_cnt_reg - 1'b1;
        if (rtrs_cnt_reg != '0) rtrs_cnt_reg <= rtrs_cnt_reg - 1'b1;
      end

      if (accept) begin
        grant_valid_reg <= 1'b0;
        last_rank_reg   <= grant_rank_reg;
        rr_ptr_reg      <= rr_ptr_next;
        if (mode_reg == MODE_WR && burst_cnt_reg < BW'(WR_BURST_MAX))
          burst_cnt_reg <= burst_cnt_reg + 1'b1;
      end else if (do_switch) begin
        mode_reg         <= (mode_reg == MODE_RD) ? MODE_WR : MODE_RD;
        // With no requester in the new mode there is no first rank yet;
        // report no change.
        rank_changed_reg <= new_found && (new_pick != last_rank_reg);
        burst_cnt_reg    <= '0;
      end else if (do_issue) begin
        grant_valid_reg    <= 1'b1;
        grant_rank_reg     <= cur_pick;
        grant_is_write_reg <= (mode_reg == MODE_WR);
      end
    end
  end

  assign grantValid   = grant_valid_reg;
  assign grantRank    = grant_rank_reg;
  assign grantIsWrite = grant_is_write_reg;
  assign channelMode  = mode_reg;
  assign rankChanged  = rank_changed_reg;

`ifndef SYNTHESIS
  wr_queue_cnt_legal: assert property (@(posedge clk) disable iff (!rst)
    wrQueueCnt <= CW'(WQ_DEPTH));
`endif

endmodule

// File: tb/tb_dq_bus_scheduler.sv
// -----------------------------------------------------------------------------
// tb_dq_bus_scheduler
// Directed scenarios plus a randomized run for dq_bus_scheduler, checked
// against a behavioural model that tracks grant timing with timestamps of the
// last accept rather than down-counters.
// -----------------------------------------------------------------------------
module tb_dq_bus_scheduler;

  localparam int NUM_RANK     = 2;
  localparam int WQ_DEPTH     = 32;
  localparam int WR_HIGH_WM   = 24;
  localparam int WR_LOW_WM    = 8;
  localparam int WR_BURST_MAX = 16;
  localparam int T_CCD        = 4;
  localparam int T_RTRS       = 2;
  localparam int RW           = 1;
  localparam int CW           = $clog2(WQ_DEPTH + 1);

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NUM_RANK-1:0] rd_req = '0;
  logic [NUM_RANK-1:0] wr_req = '0;
  logic [CW-1:0]       wr_cnt = '0;
  logic                dq_free = 1'b0;
  logic                grant_ready = 1'b0;
  logic                grant_valid;
  logic [RW-1:0]       grant_rank;
  logic                grant_is_write;
  logic                channel_mode;
  logic                rank_changed;

  always #5 clk = ~clk;

  dq_bus_scheduler #(
    .NUM_RANK     (NUM_RANK),
    .WQ_DEPTH     (WQ_DEPTH),
    .WR_HIGH_WM   (WR_HIGH_WM),
    .WR_LOW_WM    (WR_LOW_WM),
    .WR_BURST_MAX (WR_BURST_MAX),
    .tCCD         (T_CCD),
    .tRTRS        (T_RTRS)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .rdReq            (rd_req),
    .wrReq            (wr_req),
    .wrQueueCnt       (wr_cnt),
    .dqTurnaroundFree (dq_free),
    .grantValid       (grant_valid),
    .grantRank        (grant_rank),
    .grantIsWrite     (grant_is_write),
    .grantReady       (grant_ready),
    .channelMode      (channel_mode),
    .rankChanged      (rank_changed)
  );

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  // Reference model state.
  int m_mode, m_gv, m_grank, m_gwr, m_last, m_rr, m_acc, m_burst, m_rc;

  function automatic int rr_first(input logic [NUM_RANK-1:0] v, input int ptr);
    for (int k = 0; k < NUM_RANK; k++)
      if (v[(ptr + k) % NUM_RANK]) return (ptr + k) % NUM_RANK;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_gv = 0; m_grank = 0; m_gwr = 0; m_last = 0;
    m_rr = 0; m_acc = -1000; m_burst = 0; m_rc = 0;
  endtask

  // One clock: the model consumes the inputs present at the rising edge,
  // then the bench moves to the falling edge where outputs are sampled.
  task automatic step();
    int t, d;
    bit sw;
    @(posedge clk);
    d = cyc - m_acc;
    if (m_gv != 0 && grant_ready) begin
      $display("cycle %0d: grant accepted rank=%0d dir=%s", cyc, m_grank, m_gwr != 0 ? "WR" : "RD");
      m_gv   = 0;
      m_last = m_grank;
      m_rr   = (m_grank + 1) % NUM_RANK;
      m_acc  = cyc;
      if (m_mode == 1 && m_burst < WR_BURST_MAX) m_burst++;
    end else if (m_gv == 0) begin
      if (m_mode == 0)
        sw = (wr_cnt >= WR_HIGH_WM) || (rd_req == 0 && wr_req != 0);
      else
        sw = (rd_req != 0) && (wr_cnt <= WR_LOW_WM || wr_req == 0 || m_burst >= WR_BURST_MAX);
      if (sw) begin
        m_mode  = 1 - m_mode;
        t       = rr_first(m_mode == 1 ? wr_req : rd_req, m_rr);
        m_rc    = (t >= 0 && t != m_last) ? 1 : 0;
        m_burst = 0;
      end else begin
        t = rr_first(m_mode == 1 ? wr_req : rd_req, m_rr);
        // The grant becomes visible next cycle (d+1 after the last accept):
        // at least tCCD after it, and tRTRS+2 after it on a rank change.
        if (t >= 0 && dq_free && d + 1 >= T_CCD && (t == m_last || d + 1 >= T_RTRS + 2)) begin
          m_gv    = 1;
          m_grank = t;
          m_gwr   = m_mode;
        end
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b0;
    rd_req = '0; wr_req = '0; wr_cnt = '0; dq_free = 1'b0; grant_ready = 1'b0;
    repeat (2) @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({grant_valid, grant_rank, grant_is_write, channel_mode, rank_changed} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got gv=%b rank=%b wr=%b mode=%b rc=%b want all 0",
               grant_valid, grant_rank, grant_is_write, channel_mode, rank_changed);
    end
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_single_rank_read();
    int gap = 0;
    rd_req = 2'b01; wr_req = '0; wr_cnt = '0; dq_free = 1'b1; grant_ready = 1'b1;
    step();
    checks++;
    if (grant_valid !== 1'b1 || grant_rank !== 1'b0 || grant_is_write !== 1'b0) begin
      errors++;
      $display("FAIL single_first_grant: got gv=%b rank=%b wr=%b want gv=1 rank=0 wr=0",
               grant_valid, grant_rank, grant_is_write);
    end
    for (int i = 1; i <= 10; i++) begin
      step();
      if (grant_valid === 1'b1) begin
        gap = i;
        break;
      end
    end
    checks++;
    if (gap != T_CCD) begin
      errors++;
      $display("FAIL single_grant_spacing: got %0d cycles want %0d", gap, T_CCD);
    end
  endtask

  task automatic test_alternate_ranks();
    int prev_rank = -1, prev_cyc = 0, grants = 0;
    rd_req = 2'b11;
    for (int i = 0; i < 26; i++) begin
      step();
      if (grant_valid === 1'b1) begin
        grants++;
        if (prev_rank >= 0) begin
          checks++;
          if (int'(grant_rank) == prev_rank || cyc - prev_cyc != T_CCD) begin
            errors++;
            $display("FAIL alternate_grant: got rank=%0d gap=%0d want rank!=%0d gap=%0d",
                     grant_rank, cyc - prev_cyc, prev_rank, T_CCD);
          end
        end
        prev_rank = int'(grant_rank);
        prev_cyc  = cyc;
      end
    end
    checks++;
    if (grants < 5) begin
      errors++;
      $display("FAIL alternate_count: got %0d grants want at least 5", grants);
    end
  endtask

  task automatic test_high_wm_switch();
    bit seen = 0;
    rd_req = 2'b01; wr_req = 2'b01; wr_cnt = CW'(23); dq_free = 1'b1; grant_ready = 1'b1;
    repeat (6) step();
    checks++;
    if (channel_mode !== 1'b0) begin
      errors++;
      $display("FAIL wm23_mode: got %b want 0", channel_mode);
    end
    for (int i = 0; i < 10 && grant_valid !== 1'b0; i++) step();
    wr_cnt = CW'(24); dq_free = 1'b0;
    step();
    checks++;
    if (channel_mode !== 1'b1 || grant_valid !== 1'b0) begin
      errors++;
      $display("FAIL wm24_switch: got mode=%b gv=%b want mode=1 gv=0", channel_mode, grant_valid);
    end
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b0) begin
        errors++;
        $display("FAIL turnaround_block: got gv=%b want 0 while turnaround busy", grant_valid);
      end
    end
    dq_free = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      if (grant_valid === 1'b1) begin
        seen = 1;
        break;
      end
    end
    checks++;
    if (!seen || grant_is_write !== 1'b1) begin
      errors++;
      $display("FAIL first_write_grant: got seen=%0d wr=%b want seen=1 wr=1", seen, grant_is_write);
    end
  endtask

  task automatic test_burst_cap();
    int count;
    apply_reset();
    rd_req = 2'b01; wr_req = 2'b01; wr_cnt = CW'(30); dq_free = 1'b1; grant_ready = 1'b1;
    step();
    checks++;
    if (channel_mode !== 1'b1) begin
      errors++;
      $display("FAIL burst_enter_wr: got mode=%b want 1", channel_mode);
    end
    for (int visit = 0; visit < 2; visit++) begin
      if (visit == 1)
        for (int i = 0; i < 10 && channel_mode !== 1'b1; i++) step();
      count = 0;
      for (int i = 0; i < 300; i++) begin
        step();
        if (grant_valid === 1'b1) count++;
        if (channel_mode !== 1'b1) break;
      end
      checks++;
      if (count != WR_BURST_MAX || channel_mode !== 1'b0) begin
        errors++;
        $display("FAIL burst_cap_visit%0d: got writes=%0d mode=%b want writes=%0d mode=0",
                 visit, count, channel_mode, WR_BURST_MAX);
      end
    end
  endtask

  task automatic test_rank_changed();
    apply_reset();
    rd_req = '0; wr_req = 2'b01; wr_cnt = CW'(10); dq_free = 1'b1; grant_ready = 1'b1;
    step();
    checks++;
    if (channel_mode !== 1'b1 || rank_changed !== 1'b0) begin
      errors++;
      $display("FAIL rc_enter_wr: got mode=%b rc=%b want mode=1 rc=0", channel_mode, rank_changed);
    end
    for (int i = 0; i < 12 && grant_valid !== 1'b1; i++) step();
    rd_req = 2'b10; wr_cnt = CW'(5);
    for (int i = 0; i < 12 && channel_mode !== 1'b0; i++) step();
    checks++;
    if (channel_mode !== 1'b0 || rank_changed !== 1'b1) begin
      errors++;
      $display("FAIL rc_diff_rank: got mode=%b rc=%b want mode=0 rc=1", channel_mode, rank_changed);
    end
    for (int i = 0; i < 12 && grant_valid !== 1'b1; i++) step();
    checks++;
    if (grant_valid !== 1'b1 || grant_rank !== 1'b1) begin
      errors++;
      $display("FAIL rc_read_rank1: got gv=%b rank=%b want gv=1 rank=1", grant_valid, grant_rank);
    end
    rd_req = '0; wr_req = 2'b10;
    for (int i = 0; i < 12 && channel_mode !== 1'b1; i++) step();
    checks++;
    if (channel_mode !== 1'b1 || rank_changed !== 1'b0) begin
      errors++;
      $display("FAIL rc_same_rank: got mode=%b rc=%b want mode=1 rc=0", channel_mode, rank_changed);
    end
  endtask

  task automatic test_hold_and_reset();
    logic [RW-1:0] held_rank;
    logic          held_wr;
    apply_reset();
    rd_req = 2'b01; wr_req = '0; wr_cnt = '0; dq_free = 1'b1; grant_ready = 1'b0;
    step();
    held_rank = grant_rank;
    held_wr   = grant_is_write;
    wr_cnt = CW'(30); wr_req = 2'b10;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (grant_valid !== 1'b1 || grant_rank !== held_rank || grant_is_write !== held_wr ||
          channel_mode !== 1'b0) begin
        errors++;
        $display("FAIL hold_stable: got gv=%b rank=%b wr=%b mode=%b want gv=1 rank=%b wr=%b mode=0",
                 grant_valid, grant_rank, grant_is_write, channel_mode, held_rank, held_wr);
      end
    end
    grant_ready = 1'b1;
    step();
    grant_ready = 1'b0;
    checks++;
    if (grant_valid !== 1'b0 || channel_mode !== 1'b0) begin
      errors++;
      $display("FAIL hold_accept: got gv=%b mode=%b want gv=0 mode=0", grant_valid, channel_mode);
    end
    step();
    checks++;
    if (channel_mode !== 1'b1 || rank_changed !== 1'b1) begin
      errors++;
      $display("FAIL hold_switch_after_accept: got mode=%b rc=%b want mode=1 rc=1",
               channel_mode, rank_changed);
    end
    for (int i = 0; i < 12 && grant_valid !== 1'b1; i++) step();
    checks++;
    if (grant_valid !== 1'b1 || grant_rank !== 1'b1 || grant_is_write !== 1'b1) begin
      errors++;
      $display("FAIL hold_write_pending: got gv=%b rank=%b wr=%b want 1 1 1",
               grant_valid, grant_rank, grant_is_write);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({grant_valid, grant_rank, grant_is_write, channel_mode, rank_changed} !== '0) begin
      errors++;
      $display("FAIL async_reset: got gv=%b rank=%b wr=%b mode=%b rc=%b want all 0",
               grant_valid, grant_rank, grant_is_write, channel_mode, rank_changed);
    end
    @(negedge clk);
    model_reset();
    rst = 1'b1;
  endtask

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        rd_req = NUM_RANK'($urandom_range(0, 3));
        wr_req = NUM_RANK'($urandom_range(0, 3));
        wr_cnt = CW'($urandom_range(0, WQ_DEPTH));
      end
      dq_free     = ($urandom_range(0, 4) != 0);
      grant_ready = ($urandom_range(0, 2) != 0);
      step();
      checks++;
      if (grant_valid !== 1'(m_gv) || grant_rank !== RW'(m_grank) ||
          grant_is_write !== 1'(m_gwr) || channel_mode !== 1'(m_mode) ||
          rank_changed !== 1'(m_rc)) begin
        errors++;
        $display("FAIL random_cycle%0d: got gv=%b rank=%b wr=%b mode=%b rc=%b want gv=%0d rank=%0d wr=%0d mode=%0d rc=%0d",
                 cyc, grant_valid, grant_rank, grant_is_write, channel_mode, rank_changed,
                 m_gv, m_grank, m_gwr, m_mode, m_rc);
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single_rank_read();
    test_alternate_ranks();
    test_high_wm_switch();
    test_burst_cap();
    test_rank_changed();
    test_hold_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
